mem_bus_ctrl: RTL

//   Sequences CPU memory requests onto the shared tri-state memory bus feeding the program ROM and work RAM.

---
 rtl/mem_bus_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// ----------------------------------------------------------------------------
// mem_bus_ctrl
//   Sequences CPU memory requests onto the shared tri-state bus that feeds the
//   program ROM and the work RAM. Each accepted request runs through
//   IDLE -> SETUP -> ACCESS -> DONE. The controller decodes the address into
//   a ROM or RAM chip enable, with RAM mirrored across the upper address
//   space. It holds the strobe for WAIT_STATES+1 cycles, latches read data on
//   the last strobe cycle and returns a one-cycle response pulse.
//
//   Optional feature macro: ROM_WRITE_TRAP_EN
//     defined   : rsp_err pulses with rsp_valid for a ROM write or any access
//                 to the unmapped gap [ROM_SIZE, RAM_BASE)
//     undefined : rsp_err is tied low and faulting accesses complete silently
//
// Ports
//   clk        in     clock, all logic on the rising edge
//   rst_n      in     synchronous reset, active low
//   req_valid  in     request present
//   req_ready  out    controller idle and accepting a request
//   req_addr   in     request address            [ADDR_WIDTH]
//   req_we     in     1 = write, 0 = read
//   req_wdata  in     write data                 [DATA_WIDTH]
//   rsp_valid  out    one-cycle completion pulse
//   rsp_rdata  out    read data, valid with rsp_valid
//   rsp_err    out    access fault (only with ROM_WRITE_TRAP_EN)
//   bus_addr   out    device address (RAM: offset from RAM_BASE mod RAM_SIZE)
//   bus_data   inout  shared tri-state data bus
//   rom_en     out    ROM chip enable
//   ram_en     out    RAM chip enable
//   bus_oe     out    read strobe
//   bus_we     out    write strobe
// ----------------------------------------------------------------------------
module mem_bus_ctrl #(
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           ROM_SIZE    = 8192,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE    = 16'h2000,
  parameter int unsigned           RAM_SIZE    = 8192,
  parameter int unsigned           WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  output logic                  rom_en,
  output logic                  ram_en,
  output logic                  bus_oe,
  output logic                  bus_we
);

  // One extra bit so that a ROM filling the whole address space still compares correctly.
  localparam int unsigned           RAM_SPAN  = RAM_SIZE - 1;
  localparam logic [ADDR_WIDTH:0]   ROM_LIMIT = ROM_SIZE[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] RAM_MASK  = RAM_SPAN[ADDR_WIDTH-1:0];
  localparam logic [3:0]            LAST_CNT  = WAIT_STATES[3:0];

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {REG_NONE, REG_ROM, REG_RAM} region_t;

  state_t                state, state_nxt;
  region_t               region_q, dec_region;
  logic [ADDR_WIDTH-1:0] addr_q, dec_addr;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [3:0]            wait_cnt;
  logic                  accept;
  logic                  access_last;
  logic                  drive_bus;

  assign accept      = req_valid && req_ready;
  assign access_last = (state == ACCESS) && (wait_cnt == LAST_CNT);

  // Address decode of the incoming request. The gap between the ROM and RAM
  // windows stays REG_NONE, which suppresses every enable and strobe later.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    dec_region = REG_NONE;
    dec_addr   = req_addr;
    if ({1'b0, req_addr} < ROM_LIMIT) begin
      dec_region = REG_ROM;
    end else if (req_addr >= RAM_BASE) begin
      dec_region = REG_RAM;
      dec_addr   = (req_addr - RAM_BASE) & RAM_MASK;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (access_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, strobe counter and read-data latch.
  always_ff @(posedge clk) begin
    // NOTE: only these few control/data registers take reset; there is no storage array here.
    if (!rst_n) begin
      region_q <= REG_NONE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        region_q <= dec_region;
        addr_q   <= dec_addr;
        we_q     <= req_we;
        wdata_q  <= req_wdata;
      end

      if (state == ACCESS) wait_cnt <= wait_cnt + 4'd1;
      else                 wait_cnt <= '0;

      // Reads take the bus value only when a device was actually enabled.
      // Faulting writes report 0, while RAM writes keep the previous read value.
      if (access_last) begin
        if (!we_q)                      rdata_q <= (region_q == REG_NONE) ? '0 : bus_data;
        else if (region_q != REG_RAM)   rdata_q <= '0;
      end
    end
  end

  // Outputs decoded from the state and the captured request.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rom_en    = 1'b0;
    ram_en    = 1'b0;
    bus_oe    = 1'b0;
    bus_we    = 1'b0;
    drive_bus = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      SETUP: begin
        rom_en = (region_q == REG_ROM) && !we_q;
        ram_en = (region_q == REG_RAM);
      end
      ACCESS: begin
        rom_en    = (region_q == REG_ROM) && !we_q;
        ram_en    = (region_q == REG_RAM);
        bus_oe    = !we_q && (region_q != REG_NONE);
        bus_we    = we_q && (region_q == REG_RAM);
        drive_bus = we_q && (region_q == REG_RAM);
      end
      DONE: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus_addr  = addr_q;
  assign rsp_rdata = rdata_q;

  // The controller drives the bus only while strobing a RAM write. During
  // reads the devices own the bus.
  assign bus_data = drive_bus ? wdata_q : {DATA_WIDTH{1'bz}};

`ifdef ROM_WRITE_TRAP_EN
  assign rsp_err = (state == DONE) &&
                   (((region_q == REG_ROM) && we_q) || (region_q == REG_NONE));
`else
  assign rsp_err = 1'b0;
`endif

endmodule
